// File: rtl/output_display_controller.sv
// Bus value to 4-digit multiplexed seven-segment display via iterative double-dabble.
// Optional macro OUTREG_LEADING_ZERO_BLANK_EN blanks leading zeros in hundreds/tens.
module output_display_controller #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic [7:0] bus,
  input  logic       input_en,
  input  logic       signed_mode,
  output logic [6:0] display,
  output logic [3:0] anode,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t        state, state_nx;
  logic [19:0]   sr, sr_adj;
  logic [3:0]    cnt;
  logic          sign_pend;
  logic [3:0]    dig_ones, dig_tens, dig_hund;
  logic          sign_reg;
  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [7:0]    mag;
  logic          hund_blank, tens_blank;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  assign mag = (signed_mode && bus[7]) ? (~bus + 8'd1) : bus;

  always_comb begin
    sr_adj = sr;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sr[8 + 4*i +: 4] > 4'd4)
        sr_adj[8 + 4*i +: 4] = sr[8 + 4*i +: 4] + 4'd3;
    end
  end

  // A load overrides every other transition, including a pending COMMIT.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = IDLE;
      SHIFT:   if (cnt == 4'd7) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (input_en) state_nx = SHIFT;
  end

  always_ff @(posedge clk) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      sr        <= '0;
      cnt       <= '0;
      sign_pend <= 1'b0;
      dig_ones  <= '0;
      dig_tens  <= '0;
      dig_hund  <= '0;
      sign_reg  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (input_en) begin
        sr        <= {12'h000, mag};
        cnt       <= '0;
        sign_pend <= signed_mode & bus[7];
      end else begin
        case (state)
          SHIFT: begin
            sr  <= sr_adj << 1;
            cnt <= cnt + 4'd1;
          end
          COMMIT: begin
            dig_ones <= sr[11:8];
            dig_tens <= sr[15:12];
            dig_hund <= sr[19:16];
            sign_reg <= sign_pend;
            done     <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(REFRESH_DIV - 1)) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

`ifdef OUTREG_LEADING_ZERO_BLANK_EN
  assign hund_blank = (dig_hund == 4'd0);
  assign tens_blank = (dig_hund == 4'd0) && (dig_tens == 4'd0);
`else
  assign hund_blank = 1'b0;
  assign tens_blank = 1'b0;
`endif

  assign busy  = (state != IDLE);
  assign anode = ~(4'b0001 << idx);

  always_comb begin
    display = 7'b0000000;
    case (idx)
      2'd0: display = seg7(dig_ones);
      2'd1: display = tens_blank ? 7'b0000000 : seg7(dig_tens);
      2'd2: display = hund_blank ? 7'b0000000 : seg7(dig_hund);
      2'd3: display = sign_reg ? 7'b0000001 : 7'b0000000;
      default: display = 7'b0000000;
    endcase
  end

endmodule
